// File: rtl/axi_master.sv
// Single-outstanding AXI burst master: one command at a time, AW->W->B or AR->R,
// with a one-cycle done pulse carrying the transaction response.
module axi_master #(
    parameter logic [1:0]  ID         = 2'b01,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [3:0]              cmd_len,
    input  logic [1:0]              cmd_burst,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_data_valid,
    output logic                    wr_data_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_last,
    output logic                    done,
    output logic [1:0]              done_resp,
    output logic [1:0]              awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic [3:0]              awqos,
    output logic [3:0]              awregion,
    output logic                    awuser,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [1:0]              wid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wuser,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    buser,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [1:0]              arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic [3:0]              arqos,
    output logic [3:0]              arregion,
    output logic                    aruser,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [1:0]              rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    ruser,
    input  logic                    rvalid,
    output logic                    rready
);
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_REJECT
    } state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_len;
    logic [1:0]            r_burst;
    logic                  r_awvalid, r_arvalid, r_wvalid, r_wlast;
    logic                  r_rd_valid, r_rd_last, r_done, r_id_err;
    logic [DATA_WIDTH-1:0] r_wdata, r_rd_data;
    logic [1:0]            r_done_resp, r_rresp;
    logic [CNT_W-1:0]      r_beats;

    logic                  w_illegal, w_load, w_wfinal, w_rend, w_rid_bad;
    logic [CNT_W-1:0]      w_len_ext;
    logic [1:0]            w_rresp_final;
    logic                  w_unused;

    assign w_illegal = (cmd_burst == 2'b11) |
                       ((cmd_burst == 2'b10) & !((cmd_len == 4'd1) | (cmd_len == 4'd3) |
                                                 (cmd_len == 4'd7) | (cmd_len == 4'd15)));
    assign w_len_ext     = {1'b0, r_len};
    assign wr_data_ready = (r_state == S_WDATA) & (r_beats <= w_len_ext) & (!r_wvalid | wready);
    assign w_load        = wr_data_valid & wr_data_ready;
    assign w_wfinal      = r_wvalid & wready & r_wlast;
    assign w_rid_bad     = (rid != ID);
    assign w_rend        = (r_state == S_RDATA) & rvalid & ((r_beats == w_len_ext) | rlast);
    // Response of a finished read includes the beat completing on this edge
    assign w_rresp_final = (r_id_err | w_rid_bad) ? 2'b10 :
                           (rresp != 2'b00) ? rresp : r_rresp;
    assign w_unused      = ^{buser, ruser};

    always_ff @(posedge aclk) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid) w_next = w_illegal ? S_REJECT : (cmd_write ? S_WADDR : S_RADDR);
            S_WADDR:  if (awready)   w_next = S_WDATA;
            S_WDATA:  if (w_wfinal)  w_next = S_WRESP;
            S_WRESP:  if (bvalid)    w_next = S_IDLE;
            S_RADDR:  if (arready)   w_next = S_RDATA;
            S_RDATA:  if (w_rend)    w_next = S_IDLE;
            S_REJECT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath: latched command, channel valids, beat counter, read/done registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_burst     <= '0;
            r_awvalid   <= 1'b0;
            r_arvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_wdata     <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
            r_done      <= 1'b0;
            r_done_resp <= '0;
            r_rresp     <= '0;
            r_id_err    <= 1'b0;
            r_beats     <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    r_addr   <= cmd_addr;
                    r_len    <= cmd_len;
                    r_burst  <= cmd_burst;
                    r_beats  <= '0;
                    r_rresp  <= '0;
                    r_id_err <= 1'b0;
                    r_wlast  <= 1'b0;
                    if (w_illegal) begin
                        r_done      <= 1'b1;
                        r_done_resp <= 2'b10;
                    end else if (cmd_write) begin
                        r_awvalid <= 1'b1;
                    end else begin
                        r_arvalid <= 1'b1;
                    end
                end
                S_WADDR: if (awready) r_awvalid <= 1'b0;
                S_RADDR: if (arready) r_arvalid <= 1'b0;
                S_WDATA: begin
                    if (w_load) begin
                        r_wdata  <= wr_data;
                        r_wvalid <= 1'b1;
                        r_wlast  <= (r_beats == w_len_ext);
                        r_beats  <= r_beats + CNT_W'(1);
                    end else if (r_wvalid & wready) begin
                        r_wvalid <= 1'b0;
                    end
                end
                S_WRESP: if (bvalid) begin
                    r_done      <= 1'b1;
                    r_done_resp <= (bid != ID) ? 2'b10 : bresp;
                end
                S_RDATA: if (rvalid) begin
                    r_rd_data  <= rdata;
                    r_rd_valid <= 1'b1;
                    r_beats    <= r_beats + CNT_W'(1);
                    if (rresp != 2'b00) r_rresp  <= rresp;
                    if (w_rid_bad)      r_id_err <= 1'b1;
                    if (w_rend) begin
                        r_rd_last   <= 1'b1;
                        r_done      <= 1'b1;
                        r_done_resp <= w_rresp_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign bready    = (r_state == S_WRESP);
    assign rready    = (r_state == S_RDATA);
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign done      = r_done;
    assign done_resp = r_done_resp;

    assign awid     = ID;
    assign awaddr   = r_addr;
    assign awlen    = r_len;
    assign awsize   = 3'b010;
    assign awburst  = r_burst;
    assign awlock   = 1'b0;
    assign awcache  = '0;
    assign awprot   = '0;
    assign awqos    = '0;
    assign awregion = '0;
    assign awuser   = 1'b0;
    assign awvalid  = r_awvalid;

    assign wid   = ID;
    assign wdata = r_wdata;
    assign wstrb = '1;
    assign wlast = r_wlast;
    assign wuser = 1'b0;
    assign wvalid = r_wvalid;

    assign arid     = ID;
    assign araddr   = r_addr;
    assign arlen    = r_len;
    assign arsize   = 3'b010;
    assign arburst  = r_burst;
    assign arlock   = 1'b0;
    assign arcache  = '0;
    assign arprot   = '0;
    assign arqos    = '0;
    assign arregion = '0;
    assign aruser   = 1'b0;
    assign arvalid  = r_arvalid;
endmodule
